ibex_pad_bridge: RTL and testbench
==================================

Name: ibex_pad_bridge

Overview:
Pin-limited bridge between the ibex instruction and data memory ports and a narrow off-chip pad bus. It arbitrates the two ibex request channels and serialises each transaction into PIN_W-bit beats: header, address, then write data. It then deserialises the read data or write acknowledge back into ibex gnt/rvalid/rdata/err semantics. It replaces the fixed 8-bit, read-only, zero-extended pad hookup at chip top with a parametrised, bidirectional, timeout-protected link.

Parameters:
PIN_W, 8, pad bus width per direction; legal values 8, 16, 32. N = 32/PIN_W beats per word.
ARB_RR, 1, 1 = round-robin between channels; 0 = fixed data-over-instr priority.
TIMEOUT, 255, maximum idle cycles in RESP before an error response; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  ibex instruction request
instr_gnt_o  out  1  instruction grant
instr_rvalid_o  out  1  instruction response valid
instr_addr_i  in  32  instruction address
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction error (timeout)
data_req_i  in  1  ibex data request
data_gnt_o  out  1  data grant
data_rvalid_o  out  1  data response valid
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  data write data
data_rdata_o  out  32  data read data
data_err_o  out  1  data error (timeout)
pad_out_o  out  PIN_W  outbound beat
pad_out_valid_o  out  1  outbound beat valid
pad_in_i  in  PIN_W  inbound beat
pad_in_valid_i  in  1  inbound beat valid
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, rst_ni low): FSM goes to IDLE. All outputs are 0, including rdata and pad_out. The round-robin pointer favours data. Any transaction in flight is dropped, with no rvalid.
- FSM states: IDLE -> HDR -> ADDR -> (WDATA if we) -> RESP -> IDLE.
- Grant:
  - Only in IDLE. gnt is combinational in the same cycle as req; at most one gnt per cycle.
  - Instruction requests are always treated as reads with be = 4'hF.
  - On gnt, register the channel, we, be, addr and wdata. Register the next state as HDR.
- Arbitration:
  - If only one channel requests, grant it.
  - If both request with ARB_RR=1, grant the channel not served last; the pointer updates on each gnt.
  - If both request with ARB_RR=0, data always wins.
- HDR: one beat. pad_out_o[3:0]=be, [4]=we, [5]=channel (1 = data), remaining bits 0. pad_out_valid_o=1.
- ADDR: N beats, least-significant PIN_W slice first, pad_out_valid_o=1 each cycle.
- WDATA: N beats, same ordering. Skipped for reads.
- The pad outbound link has no backpressure: one beat per cycle, back to back.
- RESP: pad_out_valid_o=0.
  - Read: collect N beats on pad_in_valid_i, LSB slice first. Gaps between beats are allowed.
  - Write: the first pad_in_valid_i beat is the acknowledge; its data is ignored.
- Completion: the cycle after the final response beat is sampled, pulse rvalid on the owning channel for exactly one cycle, then return to IDLE.
  - Read: rdata = assembled word.
  - Write: rdata = 0.
  - err = 0.
- Early grant: a new gnt may occur in the same cycle as that rvalid. IDLE is entered in that cycle, and gnt is combinational on IDLE.
- Timeout:
  - The counter clears on entry to RESP and on each accepted inbound beat, and increments each RESP cycle without a beat.
  - When it reaches TIMEOUT (TIMEOUT>0), pulse rvalid with err=1 and rdata=0, return to IDLE, and discard partial data.
  - A beat arriving in the same cycle as the timeout is taken as the beat; no timeout fires that cycle.
- pad_in_valid_i outside RESP is ignored.
- rdata/err hold their value until the next rvalid on that channel.
- busy_o = (state != IDLE).
- Latency (PIN_W=8 read, gnt at cycle T, zero-wait pad):
  - HDR at T+1.
  - ADDR at T+2..T+5.
  - Response beats at T+6..T+9.
  - rvalid at T+10.

Test Plan:
- Read, PIN_W=8: instr read addr 0x0000_0080, pad returns beats 0x13,0x00,0x00,0x00 at T+6..T+9 -> header 0x0F, addr beats 0x80,0x00,0x00,0x00; instr_rvalid_o at T+10 with rdata 0x0000_0013, err 0.
- Write, PIN_W=16: data write addr 0x1000_0004, be 4'b0011, wdata 0xDEAD_BEEF, ack one cycle after the last wdata beat -> beats 0x0033,0x0004,0x1000,0xBEEF,0xDEAD; data_rvalid_o one cycle after the ack, rdata 0.
- Simultaneous requests, ARB_RR=1, both held high across 3 transactions -> grant order data, instr, data. With ARB_RR=0 -> data every time.
- Timeout, TIMEOUT=4: data read, pad never responds -> data_rvalid_o with data_err_o=1 and rdata 0, exactly 4 cycles after RESP entry. A beat on the 4th cycle prevents the timeout.
- Gapped read, PIN_W=8: response beats separated by 3 idle cycles -> correct word assembled, no error.
- Reset mid-transaction: rst_ni low during ADDR -> outputs 0 immediately. After release, no rvalid; the next request is granted from IDLE normally.

Source files
------------

// File: rtl/ibex_pad_bridge.sv
// Bridges the ibex instruction/data ports onto a narrow bidirectional pad bus.
// Each transaction is sent as header, address, then write data, and waits for a timeout-guarded response.
module ibex_pad_bridge #(
  parameter int unsigned PIN_W   = 8,
  parameter int unsigned ARB_RR  = 1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  input  logic [31:0]      instr_addr_i,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic [PIN_W-1:0] pad_out_o,
  output logic             pad_out_valid_o,
  input  logic [PIN_W-1:0] pad_in_i,
  input  logic             pad_in_valid_i,
  output logic             busy_o
);

  localparam int unsigned N  = 32 / PIN_W;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0]   LastBeat = BW'(N - 1);
  localparam logic [TO_W-1:0] ToLast   = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr   = 3'd1;
  localparam logic [2:0] StAddr  = 3'd2;
  localparam logic [2:0] StWdata = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            ch_q, we_q, rr_q;
  logic [3:0]      be_q;
  logic [31:0]     addr_q, wdata_q, acc_q, word;
  logic            instr_rvalid_q, data_rvalid_q, instr_err_q, data_err_q;
  logic [31:0]     instr_rdata_q, data_rdata_q;

  logic idle, gnt_data, gnt_instr, gnt_any;
  logic in_beat, last_beat, done_rd, done_wr, timeout, finish;

  // rr_q set means data is favoured when both channels request.
  assign idle      = (state_q == StIdle);
  assign gnt_data  = rst_ni & idle & data_req_i & (~instr_req_i | (ARB_RR == 0) | rr_q);
  assign gnt_instr = rst_ni & idle & instr_req_i & ~gnt_data;
  assign gnt_any   = gnt_data | gnt_instr;

  assign in_beat   = (state_q == StResp) & pad_in_valid_i;
  assign last_beat = (beat_q == LastBeat);
  assign done_rd   = in_beat & ~we_q & last_beat;
  assign done_wr   = in_beat & we_q;
  assign timeout   = (TIMEOUT != 0) & (state_q == StResp) & ~pad_in_valid_i & (cnt_q == ToLast);
  assign finish    = done_rd | done_wr | timeout;

  // Read word with the current inbound beat merged into its slice.
  always_comb begin
    word = acc_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (beat_q == BW'(i)) word[i*PIN_W +: PIN_W] = pad_in_i;
    end
  end

  always_comb begin
    pad_out_o       = '0;
    pad_out_valid_o = 1'b0;
    case (state_q)
      StHdr: begin
        pad_out_o       = PIN_W'({ch_q, we_q, be_q});
        pad_out_valid_o = 1'b1;
      end
      StAddr: begin
        pad_out_valid_o = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
          if (beat_q == BW'(i)) pad_out_o = addr_q[i*PIN_W +: PIN_W];
        end
      end
      StWdata: begin
        pad_out_valid_o = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
          if (beat_q == BW'(i)) pad_out_o = wdata_q[i*PIN_W +: PIN_W];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        beat_d = '0;
        if (gnt_any) state_d = StHdr;
      end
      StHdr: begin
        state_d = StAddr;
        beat_d  = '0;
      end
      StAddr: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          beat_d  = '0;
          state_d = we_q ? StWdata : StResp;
        end
      end
      StWdata: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          beat_d  = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (in_beat) beat_d = last_beat ? '0 : beat_q + 1'b1;
        if (finish) begin
          state_d = StIdle;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  // Idle counter only runs in RESP, so entering RESP always starts from zero.
  assign cnt_d = ((state_q == StResp) && !in_beat) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      beat_q         <= '0;
      cnt_q          <= '0;
      ch_q           <= 1'b0;
      we_q           <= 1'b0;
      rr_q           <= 1'b1;
      be_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      acc_q          <= '0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      instr_err_q    <= 1'b0;
      data_err_q     <= 1'b0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      if (gnt_any) begin
        ch_q    <= gnt_data;
        we_q    <= gnt_data & data_we_i;
        be_q    <= gnt_data ? data_be_i : 4'hF;
        addr_q  <= gnt_data ? data_addr_i : instr_addr_i;
        wdata_q <= gnt_data ? data_wdata_i : '0;
        rr_q    <= gnt_instr;
      end
      if (in_beat && !we_q) acc_q <= word;
      instr_rvalid_q <= finish & ~ch_q;
      data_rvalid_q  <= finish & ch_q;
      if (finish && !ch_q) begin
        instr_rdata_q <= done_rd ? word : '0;
        instr_err_q   <= timeout;
      end
      if (finish && ch_q) begin
        data_rdata_q <= done_rd ? word : '0;
        data_err_q   <= timeout;
      end
    end
  end

  assign instr_gnt_o    = gnt_instr;
  assign data_gnt_o     = gnt_data;
  assign instr_rvalid_o = instr_rvalid_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign instr_rdata_o  = instr_rdata_q;
  assign data_rdata_o   = data_rdata_q;
  assign instr_err_o    = instr_err_q;
  assign data_err_o     = data_err_q;
  assign busy_o         = ~idle;

endmodule

// File: tb/tb_ibex_pad_bridge.sv
// Bench for ibex_pad_bridge: a transaction-level model checks an 8-bit instance every cycle,
// directed literal checks pin the model, and a 16-bit fixed-priority instance is checked directly.
module tb_ibex_pad_bridge;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, round-robin, TIMEOUT=4 instance
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [7:0]  pad_out, pad_in;
  logic        pad_out_valid, pad_in_valid, busy;

  ibex_pad_bridge #(.PIN_W(8), .ARB_RR(1), .TIMEOUT(4), .TO_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .pad_out_o(pad_out), .pad_out_valid_o(pad_out_valid), .pad_in_i(pad_in),
    .pad_in_valid_i(pad_in_valid), .busy_o(busy)
  );

  // 16-bit, fixed priority, no timeout instance
  logic        b_instr_req, b_instr_gnt, b_instr_rvalid, b_instr_err;
  logic [31:0] b_instr_addr, b_instr_rdata;
  logic        b_data_req, b_data_gnt, b_data_rvalid, b_we, b_data_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_data_rdata;
  logic [15:0] b_pad_out, b_pad_in;
  logic        b_pad_out_valid, b_pad_in_valid, b_busy;

  ibex_pad_bridge #(.PIN_W(16), .ARB_RR(0), .TIMEOUT(0), .TO_W(8)) dut16 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(b_instr_req), .instr_gnt_o(b_instr_gnt), .instr_rvalid_o(b_instr_rvalid),
    .instr_addr_i(b_instr_addr), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
    .data_req_i(b_data_req), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
    .data_we_i(b_we), .data_be_i(b_be), .data_addr_i(b_addr),
    .data_wdata_i(b_wdata), .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
    .pad_out_o(b_pad_out), .pad_out_valid_o(b_pad_out_valid), .pad_in_i(b_pad_in),
    .pad_in_valid_i(b_pad_in_valid), .busy_o(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- transaction-level model of the 8-bit instance ----------------
  bit          m_busy, m_ch, m_we, m_last_data;
  logic [7:0]  m_out[$];
  int          m_rcnt, m_idle;
  logic [31:0] m_word, m_a;
  logic [3:0]  m_b;
  bit          m_rv_i, m_rv_d, m_er_i, m_er_d;
  logic [31:0] m_rd_i, m_rd_d;
  bit          e_gi, e_gd, e_pv;
  logic [7:0]  e_po;

  task automatic model_done(input logic [31:0] v, input bit e);
    m_busy = 1'b0;
    if (m_ch) begin
      m_rv_d = 1'b1; m_rd_d = v; m_er_d = e;
    end else begin
      m_rv_i = 1'b1; m_rd_i = v; m_er_i = e;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_busy = 0; m_last_data = 0; m_out.delete();
      m_rv_i = 0; m_rv_d = 0; m_er_i = 0; m_er_d = 0; m_rd_i = 0; m_rd_d = 0;
    end
    e_gi = 0;
    e_gd = 0;
    if (rst_ni && !m_busy) begin
      if (data_req && (!instr_req || !m_last_data)) e_gd = 1;
      else if (instr_req) e_gi = 1;
    end
    e_pv = m_busy && (m_out.size() != 0);
    e_po = e_pv ? m_out[0] : 8'h00;
    check("m_instr_gnt", instr_gnt, e_gi);
    check("m_data_gnt", data_gnt, e_gd);
    check("m_pad_out_valid", pad_out_valid, e_pv);
    check("m_pad_out", pad_out, e_po);
    check("m_busy", busy, m_busy);
    check("m_instr_rvalid", instr_rvalid, m_rv_i);
    check("m_data_rvalid", data_rvalid, m_rv_d);
    check("m_instr_rdata", instr_rdata, m_rd_i);
    check("m_data_rdata", data_rdata, m_rd_d);
    check("m_instr_err", instr_err, m_er_i);
    check("m_data_err", data_err, m_er_d);
    if (rst_ni) begin
      m_rv_i = 0;
      m_rv_d = 0;
      if (e_gi || e_gd) begin
        m_busy = 1; m_ch = e_gd; m_we = e_gd && data_we; m_last_data = e_gd;
        m_b = e_gd ? data_be : 4'hF;
        m_a = e_gd ? data_addr : instr_addr;
        m_out.push_back({2'b00, e_gd, m_we, m_b});
        for (int k = 0; k < 4; k++) m_out.push_back(m_a[8*k +: 8]);
        if (m_we) for (int k = 0; k < 4; k++) m_out.push_back(data_wdata[8*k +: 8]);
        m_rcnt = 0; m_idle = 0; m_word = 0;
      end else if (m_busy && m_out.size() != 0) begin
        void'(m_out.pop_front());
      end else if (m_busy) begin
        if (pad_in_valid) begin
          m_idle = 0;
          if (m_we) model_done(32'h0, 1'b0);
          else begin
            m_word[8*m_rcnt +: 8] = pad_in;
            m_rcnt++;
            if (m_rcnt == 4) model_done(m_word, 1'b0);
          end
        end else begin
          m_idle++;
          if (m_idle == 4) model_done(32'h0, 1'b1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed and random stimulus ----------------
  logic [7:0]  rd_beats[4], rd_addr[4], gap_beats[4], gap_addr[4];
  logic [15:0] w16[5];
  bit          order[3];
  int          n;

  initial begin
    rd_beats  = '{8'h13, 8'h00, 8'h00, 8'h00};
    rd_addr   = '{8'h80, 8'h00, 8'h00, 8'h00};
    gap_beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    gap_addr  = '{8'h00, 8'h02, 8'h00, 8'h00};
    w16       = '{16'h0033, 16'h0004, 16'h1000, 16'hBEEF, 16'hDEAD};
    instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; pad_in = 0; pad_in_valid = 0;
    b_instr_req = 0; b_instr_addr = 0; b_data_req = 0; b_we = 0; b_be = 0;
    b_addr = 0; b_wdata = 0; b_pad_in = 0; b_pad_in_valid = 0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    smp();
    check("reset_busy", busy, 0);
    check("reset_pad_out", pad_out, 0);
    check("reset_rdata", instr_rdata, 0);

    // Instruction read, zero-wait pad
    cyc(); instr_req = 1; instr_addr = 32'h0000_0080; smp();
    check("rd_gnt", instr_gnt, 1);
    cyc(); instr_req = 0; smp();
    check("rd_hdr", pad_out, 8'h0F);
    check("rd_hdr_valid", pad_out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); smp();
      check("rd_addr_beat", pad_out, rd_addr[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); pad_in_valid = 1; pad_in = rd_beats[i]; smp();
      check("rd_resp_quiet", pad_out_valid, 0);
    end
    cyc(); pad_in_valid = 0; smp();
    check("rd_rvalid", instr_rvalid, 1);
    check("rd_rdata", instr_rdata, 32'h0000_0013);
    check("rd_err", instr_err, 0);
    cyc(); smp();
    check("rd_rvalid_pulse", instr_rvalid, 0);
    check("rd_rdata_hold", instr_rdata, 32'h0000_0013);

    // Data read with 3 idle cycles before each beat: no timeout, word assembled
    cyc(); data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h0000_0200; smp();
    check("gap_gnt", data_gnt, 1);
    cyc(); data_req = 0; smp();
    check("gap_hdr", pad_out, 8'h2F);
    for (int i = 0; i < 4; i++) begin
      cyc(); smp();
      check("gap_addr_beat", pad_out, gap_addr[i]);
    end
    for (int k = 0; k < 16; k++) begin
      cyc(); pad_in_valid = (k % 4 == 3); pad_in = gap_beats[k/4]; smp();
      check("gap_no_rvalid", data_rvalid, 0);
    end
    cyc(); pad_in_valid = 0; smp();
    check("gap_rvalid", data_rvalid, 1);
    check("gap_rdata", data_rdata, 32'h4433_2211);
    check("gap_err", data_err, 0);

    // Data read with silent pad: error exactly 4 cycles after RESP entry
    cyc(); data_req = 1; data_addr = 32'h0000_0300; smp();
    check("to_gnt", data_gnt, 1);
    for (int k = 0; k < 9; k++) begin
      cyc(); data_req = 0; smp();
      check("to_no_rvalid", data_rvalid, 0);
    end
    cyc(); smp();
    check("to_rvalid", data_rvalid, 1);
    check("to_err", data_err, 1);
    check("to_rdata", data_rdata, 0);
    check("to_busy", busy, 0);
    cyc(); smp();
    check("to_rvalid_pulse", data_rvalid, 0);
    check("to_err_hold", data_err, 1);

    // Randomized traffic with varying pad responsiveness
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        cyc();
        instr_req    = 1'($urandom_range(0, 1));
        data_req     = 1'($urandom_range(0, 1));
        data_we      = 1'($urandom_range(0, 1));
        data_be      = 4'($urandom);
        instr_addr   = $urandom;
        data_addr    = $urandom;
        data_wdata   = $urandom;
        pad_in       = 8'($urandom);
        pad_in_valid = ($urandom_range(0, 99) < ((blk % 3 == 0) ? 95 : (blk % 3 == 1) ? 60 : 35));
      end
    end
    cyc(); instr_req = 0; data_req = 0; pad_in_valid = 1;
    repeat (20) cyc();

    // Reset during ADDR: outputs drop at once, nothing completes afterwards
    instr_req = 1; instr_addr = 32'h0000_0100; pad_in_valid = 0; smp();
    check("rst_gnt", instr_gnt, 1);
    cyc(); instr_req = 0; smp();
    cyc(); smp();
    check("rst_in_addr", pad_out_valid, 1);
    cyc(); rst_ni = 0; #1;
    check("rst_async_valid", pad_out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_out", pad_out, 0);
    cyc(); cyc(); rst_ni = 1;
    for (int k = 0; k < 12; k++) begin
      cyc(); pad_in_valid = 1; pad_in = 8'($urandom); smp();
      check("rst_no_rvalid", instr_rvalid, 0);
    end

    // Both channels held high, round-robin: data, instr, data
    cyc(); instr_req = 1; data_req = 1; data_we = 0; pad_in_valid = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      smp();
      if (data_gnt || instr_gnt) begin
        order[n] = data_gnt;
        n++;
      end
      cyc();
    end
    instr_req = 0; data_req = 0;
    check("rr_grant_count", n, 3);
    check("rr_first_data", order[0], 1);
    check("rr_second_instr", order[1], 0);
    check("rr_third_data", order[2], 1);
    repeat (15) cyc();

    // 16-bit write
    b_data_req = 1; b_we = 1; b_be = 4'b0011; b_addr = 32'h1000_0004; b_wdata = 32'hDEAD_BEEF;
    smp();
    check("w16_gnt", b_data_gnt, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); b_data_req = 0; smp();
      check("w16_beat", b_pad_out, w16[i]);
      check("w16_beat_valid", b_pad_out_valid, 1);
    end
    cyc(); b_pad_in_valid = 1; b_pad_in = 16'h5A5A; smp();
    check("w16_ack_quiet", b_pad_out_valid, 0);
    check("w16_no_early_rvalid", b_data_rvalid, 0);
    cyc(); b_pad_in_valid = 0; smp();
    check("w16_rvalid", b_data_rvalid, 1);
    check("w16_rdata", b_data_rdata, 0);
    check("w16_err", b_data_err, 0);

    // Fixed priority: data wins every time
    cyc(); b_instr_req = 1; b_data_req = 1; b_we = 0; b_pad_in_valid = 1; b_pad_in = 16'h1234;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      smp();
      if (b_data_gnt || b_instr_gnt) begin
        order[n] = b_data_gnt;
        n++;
      end
      cyc();
    end
    b_instr_req = 0; b_data_req = 0; b_pad_in_valid = 0;
    check("fp_grant_count", n, 3);
    for (int i = 0; i < 3; i++) check("fp_data_wins", order[i], 1);
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
